// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//
// Single-outstanding APB initiator. It accepts one request on a valid/ready
// request channel, runs a SETUP/ACCESS transfer on the APB bus, and returns
// the read data and error status on a valid/ready response channel. No new
// request is taken until the previous response has been consumed.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both 1. The side driving valid keeps valid
// and its payload stable until that edge.
//
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase
// that is still waiting for pready in its TIMEOUT-th cycle. The aborted
// transfer completes with rsp_err=1 and rsp_rdata=0.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/ready     request handshake
//   req_addr/write/wdata/wstrb   request payload
//   rsp_valid/ready     response handshake
//   rsp_rdata, rsp_err  response payload
//   psel, penable, paddr, pwrite, pwdata, pwstrb   APB outputs (registered)
//   pready, prdata, pslverr                        APB completer inputs
// ---------------------------------------------------------------------------
module apb_master #(
    parameter int ADDR_WIDTH = 26,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_write,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  psel,
    output logic                  penable,
    input  logic                  pready,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pwrite,
    output logic [31:0]           pwdata,
    output logic [3:0]            pwstrb,
    input  logic [31:0]           prdata,
    input  logic                  pslverr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // A zero or negative abort limit would make the ACCESS phase meaningless.
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("apb_master: TIMEOUT must be >= 1");
    end

    state_e                state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [31:0]           pwdata_q, pwdata_d;
    logic [3:0]            pwstrb_q, pwstrb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Value of the counter during the TIMEOUT-th ACCESS cycle (counter starts
    // at 0 in the first ACCESS cycle).
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pwstrb_d    = pwstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d  = ST_SETUP;
                    psel_d   = 1'b1;
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    // Reads carry zero data but full strobes: completers
                    // check strobes on every transfer.
                    pwdata_d = req_write ? req_wdata : 32'h0;
                    pwstrb_d = req_write ? req_wstrb : 4'hF;
`ifdef APB_MASTER_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end

            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end

            ST_ACCESS: begin
                // pready has priority over a timeout in the same cycle.
                if (pready) begin
                    state_d     = ST_RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr;
                    rsp_rdata_d = pwrite_q ? 32'h0 : prdata;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= 32'h0;
            pwstrb_q    <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pwstrb_q    <= pwstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign pwstrb    = pwstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Single-outstanding APB initiator. Converts a valid/ready request/response interface into APB SETUP/ACCESS transfers toward the peripheral bus (PLIC, timers, UART completers).
- Sits between the core-side memory-mapped I/O path and the APB interconnect.
- Holds the transfer until the completer asserts pready, then returns read data and error status.

Parameters:
ADDR_WIDTH, 26, width of req_addr and paddr
TIMEOUT, 255, max ACCESS cycles before forced abort (used only with APB_MASTER_TIMEOUT_EN); must be >= 1

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request valid
req_ready  output  1  request accepted when req_valid & req_ready
req_addr  input  ADDR_WIDTH  byte address
req_write  input  1  1 = write, 0 = read
req_wdata  input  32  write data
req_wstrb  input  4  write byte strobes
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  output  32  read data
rsp_err  output  1  transfer error
psel  output  1  APB select
penable  output  1  APB enable
pready  input  1  completer ready
paddr  output  ADDR_WIDTH  APB address
pwrite  output  1  APB direction
pwdata  output  32  APB write data
pwstrb  output  4  APB strobes
prdata  input  32  APB read data
pslverr  input  1  APB error

Behaviour:
- Reset (rst_n low at clk edge): state IDLE. psel=0, penable=0, paddr=0, pwrite=0, pwdata=0, pwstrb=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. Any in-flight transfer or pending response is dropped.
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB outputs and response outputs are registered. req_ready = (state==IDLE), combinational from state.
- IDLE: on req_valid, latch the request. Next state SETUP. In SETUP, psel=1 and penable=0.
- Latched request fields:
  - paddr = req_addr, pwrite = req_write.
  - Writes: pwdata = req_wdata, pwstrb = req_wstrb.
  - Reads: pwdata = 0, pwstrb = 4'hF, because team completers check strobes on every transfer.
- SETUP -> ACCESS unconditionally after one cycle. In ACCESS, psel=1 and penable=1.
- ACCESS:
  - pready=0: stay in ACCESS; paddr, pwrite, pwdata and pwstrb are held stable.
  - pready=1: sample prdata and pslverr. Next state RESP, with psel=0, penable=0, rsp_valid=1.
  - rsp_err = pslverr.
  - rsp_rdata = prdata for reads, including errored reads; 0 for writes.
- RESP: hold rsp_valid, rsp_rdata and rsp_err until rsp_ready. Then rsp_valid=0 and next state IDLE. No new request is accepted before that.
- Latency, zero-wait completer:
  - Accept at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3.
  - Earliest next accept is cycle 4 if rsp_ready=1 at cycle 3.
  - Each completer wait state adds one cycle.
- paddr, pwrite, pwdata and pwstrb keep their last values after a transfer. They change only on accept or reset.
- psel never rises without passing through SETUP. penable is never 1 while psel is 0.
- Alignment and strobe legality are not checked here; completers report violations via pslverr.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined: a counter of width $clog2(TIMEOUT+1) counts ACCESS cycles, cleared on entry to SETUP.
  - If pready is still 0 in the TIMEOUT-th ACCESS cycle, the next state is RESP with psel=0, penable=0, rsp_err=1, rsp_rdata=0.
  - pready=1 in that same cycle wins and gives a normal completion.
- Not defined: no counter; ACCESS waits for pready indefinitely.

Test Plan:
1. Zero-wait write:
   - Stimulus: addr 0x0000004, wdata 0xDEADBEEF, wstrb F, pready=1.
   - Required: cycle 1 psel=1 penable=0; cycle 2 penable=1; cycle 3 rsp_valid=1, rsp_err=0, rsp_rdata=0, psel=0.
2. Read with 3 wait states:
   - Stimulus: addr 0x0200000; pready=0 for 3 ACCESS cycles, then pready=1 with prdata 0x12345678.
   - Required: ACCESS lasts 4 cycles with paddr/pwstrb(F) stable; rsp_rdata=0x12345678, rsp_err=0.
3. Errored write:
   - Stimulus: pslverr=1 with pready=1.
   - Required: rsp_err=1, rsp_rdata=0. Errored read with prdata 0xA5A5A5A5 -> rsp_err=1, rsp_rdata=0xA5A5A5A5.
4. Response backpressure:
   - Stimulus: rsp_ready=0 for 5 cycles while req_valid=1.
   - Required: rsp_valid and data held, req_ready=0, psel=0 throughout. Accept occurs the cycle after rsp_ready=1.
5. Reset mid-ACCESS:
   - Stimulus: rst_n=0 for one edge during a stalled transfer.
   - Required: next cycle psel=0, penable=0, rsp_valid=0, req_ready=1, all APB outputs 0.
6. Timeout (APB_MASTER_TIMEOUT_EN, TIMEOUT=8):
   - Stimulus: pready held 0.
   - Required: exactly 8 ACCESS cycles, then rsp_err=1, rsp_rdata=0. Without the macro, psel remains 1 after 100 cycles.
